// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: FSM encoding, register offsets,
// character codes and geometry defaults.
package console_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;
  localparam int CELLS_DEF = COLS_DEF * ROWS_DEF;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int CUR_W = 8;
  localparam int CX_W  = $clog2(COLS_DEF);
  localparam int CY_W  = $clog2(ROWS_DEF);

  localparam logic [AW-1:0] BASE_DEF = 12'h081;
  localparam logic [DW-1:0] FILL_DEF = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUT     = 2'd1,
    ST_CLR_ROW = 2'd2,
    ST_CLR_ALL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OFF_DATA = 2'd0,
    OFF_CX   = 2'd1,
    OFF_CY   = 2'd2,
    OFF_CTRL = 2'd3
  } reg_off_t;

  localparam logic [DW-1:0] CH_LF       = 8'h0A;
  localparam logic [DW-1:0] CH_CR       = 8'h0D;
  localparam logic [DW-1:0] CH_BS       = 8'h08;
  localparam logic [DW-1:0] CH_PRINT_LO = 8'h20;
  localparam logic [DW-1:0] CH_PRINT_HI = 8'h7E;

  // Constant-coefficient product; only used when software repositions the row.
  function automatic logic [AW-1:0] row_base(input logic [CUR_W-1:0] row, input int cols);
    return AW'(row) * AW'(cols);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// CPU IO bus plus text-RAM write port of the console, with an FSM state tap.
interface text_console_if;
  import console_pkg::*;

  // IO: io_w_en/io_r_en are single-cycle strobes sampled on posedge clk with
  // address/din; dout is registered and changes only after a decoded read.
  // Text RAM: every cycle v_w_en is high is exactly one cell write.
  logic [AW-1:0] address;
  logic [DW-1:0] din;
  logic          io_w_en;
  logic          io_r_en;
  logic [DW-1:0] dout;
  logic          v_w_en;
  logic [AW-1:0] v_addr;
  logic [DW-1:0] v_din;
  state_t        state;

  modport master (
    output address, din, io_w_en, io_r_en,
    input  dout, v_w_en, v_addr, v_din, state
  );

  modport slave (
    input  address, din, io_w_en, io_r_en,
    output dout, v_w_en, v_addr, v_din, state
  );
endinterface

// File: rtl/text_console.sv
// Terminal front end: owns the cursor, turns CPU character writes into
// single-cycle text-RAM cell writes, and clears rows / the whole screen.
module text_console
  import console_pkg::*;
#(
  parameter int            COLS = COLS_DEF,
  parameter int            ROWS = ROWS_DEF,
  parameter logic [AW-1:0] BASE = BASE_DEF,
  parameter logic [DW-1:0] FILL = FILL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  text_console_if.slave bus
);

  localparam logic [AW-1:0]    L_COLS      = AW'(COLS);
  localparam logic [AW-1:0]    L_LAST_CELL = AW'(COLS * ROWS - 1);
  localparam logic [CUR_W-1:0] L_COL_MAX   = CUR_W'(COLS - 1);
  localparam logic [CUR_W-1:0] L_ROW_MAX   = CUR_W'(ROWS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CUR_W-1:0] r_cx;
  logic [CUR_W-1:0] r_cy;
  logic [AW-1:0]    r_row_base;
  logic [AW-1:0]    r_cnt;
  logic             r_wrap;
  logic             r_ovf;
  logic [DW-1:0]    r_dout;
  logic             r_v_w_en;
  logic [AW-1:0]    r_v_addr;
  logic [DW-1:0]    r_v_din;

  logic [AW-1:0]    w_off;
  reg_off_t         w_reg;
  logic             w_hit;
  logic             w_wr;
  logic             w_rd;
  logic             w_busy;
  logic             w_data_wr;
  logic             w_cx_wr;
  logic             w_cy_wr;
  logic             w_ctrl_wr;
  logic             w_clr_req;
  logic             w_ovf_clr;
  logic             w_drop;
  logic             w_printable;
  logic             w_cx_last;
  logic [CUR_W-1:0] w_next_row;
  logic [AW-1:0]    w_next_base;
  logic             w_filling;
  logic             w_fill_done;
  logic [CUR_W-1:0] w_cx_sat;
  logic [CUR_W-1:0] w_cy_sat;
  logic             w_do_put;
  logic             w_do_bs;
  logic             w_do_lf;
  logic             w_do_cr;
  logic             w_do_all;

  assign w_off     = bus.address - BASE;
  assign w_hit     = (w_off[AW-1:2] == '0);
  assign w_reg     = reg_off_t'(w_off[1:0]);
  assign w_wr      = bus.io_w_en & w_hit;
  assign w_rd      = bus.io_r_en & ~bus.io_w_en & w_hit;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_data_wr = w_wr & (w_reg == OFF_DATA);
  assign w_cx_wr   = w_wr & (w_reg == OFF_CX);
  assign w_cy_wr   = w_wr & (w_reg == OFF_CY);
  assign w_ctrl_wr = w_wr & (w_reg == OFF_CTRL);
  assign w_clr_req = w_ctrl_wr & bus.din[1];
  assign w_ovf_clr = w_ctrl_wr & bus.din[2];
  assign w_drop    = w_busy & (w_data_wr | w_cx_wr | w_cy_wr | w_clr_req);

  assign w_printable = (bus.din >= CH_PRINT_LO) && (bus.din <= CH_PRINT_HI);
  assign w_cx_last   = (r_cx == L_COL_MAX);
  // Row base advances by COLS per newline, so no multiply on the character path.
  assign w_next_row  = (r_cy == L_ROW_MAX) ? '0 : r_cy + 1'b1;
  assign w_next_base = (r_cy == L_ROW_MAX) ? '0 : r_row_base + L_COLS;
  assign w_filling   = (r_state == ST_CLR_ROW) || (r_state == ST_CLR_ALL);
  assign w_fill_done = (r_cnt == '0);
  assign w_cx_sat    = (bus.din >= CUR_W'(COLS)) ? L_COL_MAX : bus.din;
  assign w_cy_sat    = (bus.din >= CUR_W'(ROWS)) ? L_ROW_MAX : bus.din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_do_put     = 1'b0;
    w_do_bs      = 1'b0;
    w_do_lf      = 1'b0;
    w_do_cr      = 1'b0;
    w_do_all     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_clr_req) begin
          w_do_all     = 1'b1;
          w_state_next = ST_CLR_ALL;
        end else if (w_data_wr) begin
          if (w_printable) begin
            w_do_put     = 1'b1;
            w_state_next = ST_PUT;
          end else if (bus.din == CH_LF) begin
            w_do_lf      = 1'b1;
            w_state_next = ST_CLR_ROW;
          end else if (bus.din == CH_CR) begin
            w_do_cr = 1'b1;
          end else if ((bus.din == CH_BS) && (r_cx != '0)) begin
            w_do_bs      = 1'b1;
            w_state_next = ST_PUT;
          end
        end
      end
      ST_PUT:     w_state_next = r_wrap ? ST_CLR_ROW : ST_IDLE;
      ST_CLR_ROW,
      ST_CLR_ALL: if (w_fill_done) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx       <= '0;
      r_cy       <= '0;
      r_row_base <= '0;
      r_cnt      <= '0;
      r_wrap     <= 1'b0;
      r_v_w_en   <= 1'b0;
      r_v_addr   <= '0;
      r_v_din    <= '0;
    end else begin
      if (w_do_put) begin
        r_v_w_en <= 1'b1;
        r_v_addr <= r_row_base + AW'(r_cx);
        r_v_din  <= bus.din;
        r_wrap   <= w_cx_last;
        if (w_cx_last) begin
          r_cx       <= '0;
          r_cy       <= w_next_row;
          r_row_base <= w_next_base;
        end else begin
          r_cx <= r_cx + 1'b1;
        end
      end else if (w_do_bs) begin
        r_v_w_en <= 1'b1;
        r_v_addr <= r_row_base + AW'(r_cx - 1'b1);
        r_v_din  <= FILL;
        r_wrap   <= 1'b0;
        r_cx     <= r_cx - 1'b1;
      end else if (w_do_lf) begin
        r_cx       <= '0;
        r_cy       <= w_next_row;
        r_row_base <= w_next_base;
        r_v_w_en   <= 1'b1;
        r_v_addr   <= w_next_base;
        r_v_din    <= FILL;
        r_cnt      <= L_COLS - 1'b1;
      end else if (w_do_cr) begin
        r_cx <= '0;
      end else if (w_do_all) begin
        r_cx       <= '0;
        r_cy       <= '0;
        r_row_base <= '0;
        r_v_w_en   <= 1'b1;
        r_v_addr   <= '0;
        r_v_din    <= FILL;
        r_cnt      <= L_LAST_CELL;
      end else if ((r_state == ST_PUT) && r_wrap) begin
        // Cursor already sits on the new row; clear it from column 0.
        r_v_w_en <= 1'b1;
        r_v_addr <= r_row_base;
        r_v_din  <= FILL;
        r_cnt    <= L_COLS - 1'b1;
      end else if (w_filling && !w_fill_done) begin
        r_v_addr <= r_v_addr + 1'b1;
        r_cnt    <= r_cnt - 1'b1;
      end else begin
        r_v_w_en <= 1'b0;
      end

      if (w_cx_wr && !w_busy) r_cx <= w_cx_sat;
      if (w_cy_wr && !w_busy) begin
        r_cy       <= w_cy_sat;
        r_row_base <= row_base(w_cy_sat, COLS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_ovf_clr)   r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;

      if (w_rd) begin
        unique case (w_reg)
          OFF_DATA: r_dout <= '0;
          OFF_CX:   r_dout <= r_cx;
          OFF_CY:   r_dout <= r_cy;
          OFF_CTRL: r_dout <= {5'b0, r_ovf, 1'b0, w_busy};
          default:  r_dout <= '0;
        endcase
      end
    end
  end

  assign bus.dout   = r_dout;
  assign bus.v_w_en = r_v_w_en;
  assign bus.v_addr = r_v_addr;
  assign bus.v_din  = r_v_din;
  assign bus.state  = r_state;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a screen-level model predicts every
// text-RAM write and register read value from cursor arithmetic.
module tb_text_console;
  import console_pkg::*;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [11:0] A_DATA = 12'h081;
  localparam logic [11:0] A_CX   = 12'h082;
  localparam logic [11:0] A_CY   = 12'h083;
  localparam logic [11:0] A_CTRL = 12'h084;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  text_console_if bus ();
  text_console dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_cx, m_cy;
  bit m_ovf;
  int busy_cycles;
  logic [7:0] rd;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Screen model: cell address is plain row*COLS+col.
  function automatic void push_cell(input int row, input int col, input logic [7:0] d);
    exp_q.push_back({12'(row * COLS + col), d});
  endfunction

  function automatic void model_newline();
    m_cy = (m_cy == ROWS - 1) ? 0 : m_cy + 1;
    for (int c = 0; c < COLS; c++) push_cell(m_cy, c, 8'h20);
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [7:0] d);
    bit busy;
    busy = (exp_q.size() != 0);
    case (a)
      A_DATA: begin
        if (busy) m_ovf = 1'b1;
        else if (d >= 8'h20 && d <= 8'h7E) begin
          push_cell(m_cy, m_cx, d);
          if (m_cx == COLS - 1) begin
            m_cx = 0;
            model_newline();
          end else m_cx++;
        end else if (d == 8'h0A) begin
          m_cx = 0;
          model_newline();
        end else if (d == 8'h0D) m_cx = 0;
        else if (d == 8'h08 && m_cx > 0) begin
          m_cx--;
          push_cell(m_cy, m_cx, 8'h20);
        end
      end
      A_CX: if (busy) m_ovf = 1'b1; else m_cx = (d >= COLS) ? COLS - 1 : int'(d);
      A_CY: if (busy) m_ovf = 1'b1; else m_cy = (d >= ROWS) ? ROWS - 1 : int'(d);
      A_CTRL: begin
        if (d[1]) begin
          if (busy) m_ovf = 1'b1;
          else begin
            m_cx = 0;
            m_cy = 0;
            for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back({12'(i), 8'h20});
          end
        end
        if (d[2]) m_ovf = 1'b0;
      end
      default: ;
    endcase
  endfunction

  function automatic int ctrl_exp(input bit busy);
    return {5'b0, m_ovf, 1'b0, busy};
  endfunction

  // Compare process: every RAM write must be the next predicted one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.state != ST_IDLE) busy_cycles++;
      if (bus.v_w_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL vram_extra: got write addr %0d data 0x%0h, want none", bus.v_addr, bus.v_din);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          check("vram_addr", bus.v_addr, e[19:8]);
          check("vram_din", bus.v_din, e[7:0]);
        end
      end
    end
  end

  task automatic io_wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    model_write(a, d);
    bus.address = a;
    bus.din     = d;
    bus.io_w_en = 1'b1;
    @(posedge clk);
    #1 bus.io_w_en = 1'b0;
  endtask

  task automatic io_wr_rd(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    model_write(a, d);
    bus.address = a;
    bus.din     = d;
    bus.io_w_en = 1'b1;
    bus.io_r_en = 1'b1;
    @(posedge clk);
    #1;
    bus.io_w_en = 1'b0;
    bus.io_r_en = 1'b0;
  endtask

  task automatic io_rd(input logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.address = a;
    bus.io_r_en = 1'b1;
    @(posedge clk);
    #1 bus.io_r_en = 1'b0;
    d = bus.dout;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.state != ST_IDLE) && n <= budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.address = '0;
    bus.din = '0;
    bus.io_w_en = 1'b0;
    bus.io_r_en = 1'b0;
    m_cx = 0; m_cy = 0; m_ovf = 1'b0; busy_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_v_w_en", bus.v_w_en, 0);
    check("rst_v_addr", bus.v_addr, 0);
    check("rst_v_din", bus.v_din, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_state", bus.state, ST_IDLE);
    @(negedge clk) rst_n = 1'b1;
    io_rd(A_CX, rd);   check("rst_cx", rd, 0);
    io_rd(A_CY, rd);   check("rst_cy", rd, 0);
    io_rd(A_CTRL, rd); check("rst_ctrl", rd, ctrl_exp(0));

    // 1: first character, one-cycle latency
    io_wr(A_DATA, 8'h41);
    check("t1_model_depth", exp_q.size(), 1);
    check("t1_model_cell", exp_q[0], {12'd0, 8'h41});
    check("t1_v_w_en", bus.v_w_en, 1);
    check("t1_v_addr", bus.v_addr, 0);
    check("t1_v_din", bus.v_din, 8'h41);
    wait_idle("t1", 10);
    io_rd(A_CX, rd); check("t1_cx", rd, 1);
    io_rd(A_DATA, rd); check("t1_data_rd", rd, 0);

    // 2: last-column character wraps and clears the next row
    io_wr(A_CX, 8'd79);
    io_wr(A_CY, 8'd0);
    busy_cycles = 0;
    io_wr(A_DATA, 8'h5A);
    check("t2_model_depth", exp_q.size(), 81);
    check("t2_model_put", exp_q[0], {12'd79, 8'h5A});
    check("t2_model_first", exp_q[1], {12'd80, 8'h20});
    check("t2_model_last", exp_q[80], {12'd159, 8'h20});
    wait_idle("t2", 200);
    check("t2_busy_cycles", busy_cycles, 81);
    io_rd(A_CX, rd); check("t2_cx", rd, m_cx);
    io_rd(A_CY, rd); check("t2_cy", rd, 1);

    // 3: LF on the last row recycles row 0
    io_wr(A_CY, 8'd29);
    io_wr(A_DATA, 8'h0A);
    check("t3_model_depth", exp_q.size(), 80);
    check("t3_model_first", exp_q[0], {12'd0, 8'h20});
    wait_idle("t3", 200);
    io_rd(A_CTRL, rd); check("t3_ctrl", rd, ctrl_exp(0));
    io_rd(A_CY, rd);   check("t3_cy", rd, 0);

    // 4: backspace, and backspace at column 0
    io_wr(A_CX, 8'd5);
    io_wr(A_CY, 8'd2);
    io_wr(A_DATA, 8'h08);
    check("t4_model_cell", exp_q[0], {12'd164, 8'h20});
    wait_idle("t4", 10);
    io_rd(A_CX, rd); check("t4_cx", rd, 4);
    io_wr(A_CX, 8'd0);
    io_wr(A_DATA, 8'h08);
    check("t4_bs0_model", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    io_rd(A_CX, rd); check("t4_bs0_cx", rd, 0);

    // CR, ignored codes, top printable code
    io_wr(A_CX, 8'd10);
    io_wr(A_DATA, 8'h0D);
    io_rd(A_CX, rd); check("cr_cx", rd, 0);
    io_wr(A_CX, 8'd7);
    io_wr(A_DATA, 8'h01);
    io_wr(A_DATA, 8'h7F);
    io_rd(A_CX, rd); check("ign_cx", rd, 7);
    io_wr(A_DATA, 8'h7E);
    wait_idle("tilde", 10);
    io_rd(A_CX, rd); check("tilde_cx", rd, 8);

    // Simultaneous write+read: write lands, dout holds; undecoded reads hold dout
    io_wr_rd(A_CX, 8'd20);
    check("rw_dout_hold", bus.dout, 8);
    io_rd(A_CX, rd); check("rw_cx", rd, 20);
    io_rd(12'h080, rd); check("undec_lo_hold", rd, 20);
    io_rd(12'h085, rd); check("undec_hi_hold", rd, 20);

    // 5: full clear, drops while busy, overflow clear
    io_wr(A_CTRL, 8'h02);
    check("t5_model_depth", exp_q.size(), 2400);
    repeat (50) @(posedge clk);
    io_wr(A_DATA, 8'h41);
    io_rd(A_CTRL, rd); check("t5_ctrl_ovf", rd, 8'h05);
    io_wr(A_CTRL, 8'h04);
    io_rd(A_CTRL, rd); check("t5_ctrl_clr", rd, 8'h01);
    io_wr(A_CX, 8'd9);
    io_rd(A_CTRL, rd); check("t5_ctrl_cxdrop", rd, ctrl_exp(1));
    io_rd(A_CX, rd); check("t5_cx_kept", rd, 0);
    io_wr(A_CTRL, 8'h04);
    wait_idle("t5", 3000);
    io_rd(A_CTRL, rd); check("t5_ctrl_idle", rd, 8'h00);
    io_rd(A_CY, rd);   check("t5_cy", rd, 0);

    // 6: reset during a full clear
    io_wr(A_CX, 8'd3);
    io_wr(A_CTRL, 8'h02);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_cx = 0; m_cy = 0; m_ovf = 1'b0;
    #1;
    check("t6_v_w_en_async", bus.v_w_en, 0);
    check("t6_state_async", bus.state, ST_IDLE);
    @(negedge clk) rst_n = 1'b1;
    io_rd(A_CTRL, rd); check("t6_ctrl", rd, 0);
    io_rd(A_CX, rd);   check("t6_cx", rd, 0);
    io_rd(A_CY, rd);   check("t6_cy", rd, 0);
    io_wr(A_CX, 8'd200);
    io_rd(A_CX, rd);   check("t6_cx_sat", rd, 79);
    io_wr(A_CY, 8'd255);
    io_rd(A_CY, rd);   check("t6_cy_sat", rd, 29);

    // Bottom-right cell, then wrap back to row 0
    io_wr(A_DATA, 8'h71);
    check("br_model_cell", exp_q[0], {12'd2399, 8'h71});
    wait_idle("br", 200);
    io_rd(A_CY, rd); check("br_cy", rd, 0);
    io_rd(A_CX, rd); check("br_cx", rd, 0);

    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
